// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, ROM address and decoder-facing instruction queue
// Optional build macro: FETCH_BRANCH_PREDECODE_EN (follow unconditional B at fetch, flag on instr_pred)

module instr_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             push,
  input  logic                             pop,
  input  logic [W-1:0]                     wdata,
  output logic [W-1:0]                     rdata,
  output logic [$clog2(DEPTH+1)-1:0]       count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // Flush takes priority over a coincident push/pop so flushed entries are never delivered.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (!push && pop)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[tail] <= wdata;
  end

  assign rdata = mem[head];
endmodule

module instr_fetch_unit #(
  parameter int ADDR_W      = 11,
  parameter int INSTR_W     = 22,
  parameter int RESET_PC    = 0,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_pred,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               busy
);
  localparam int CW = $clog2(QUEUE_DEPTH+1);
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
`ifdef FETCH_BRANCH_PREDECODE_EN
  localparam int EW = INSTR_W + ADDR_W + 1;
`else
  localparam int EW = INSTR_W + ADDR_W;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  next_pc;
  logic [CW-1:0]      q_count;
  logic [EW-1:0]      q_wdata;
  logic [EW-1:0]      q_rdata;
  logic               q_full;
  logic               pop;
  logic               push;
  logic               flush;

  assign rom_addr    = pc;
  assign instr_valid = (q_count != '0);
  assign q_full      = (q_count == CW'(QUEUE_DEPTH));
  assign pop         = instr_valid & instr_ready;
  assign flush       = start | redirect_valid;
  assign push        = (state == RUN) & ~redirect_valid & ~stop & ~start & (~q_full | pop);

  assign instr_data  = instr_valid ? q_rdata[EW-1 -: INSTR_W] : '0;

`ifdef FETCH_BRANCH_PREDECODE_EN
  logic is_branch;
  assign is_branch  = (rom_data[INSTR_W-1 -: 5] == 5'b10010);
  assign next_pc    = is_branch ? rom_data[ADDR_W-1:0] : pc + ADDR_W'(1);
  assign q_wdata    = {rom_data, pc, is_branch};
  assign instr_pc   = instr_valid ? q_rdata[ADDR_W:1] : '0;
  assign instr_pred = instr_valid & q_rdata[0];
`else
  assign next_pc    = pc + ADDR_W'(1);
  assign q_wdata    = {rom_data, pc};
  assign instr_pc   = instr_valid ? q_rdata[ADDR_W-1:0] : '0;
  assign instr_pred = 1'b0;
`endif

  // Priority: rst > start > redirect > stop/push. Redirect leaves state alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      pc    <= PC_INIT;
    end else if (start) begin
      state <= RUN;
      busy  <= 1'b1;
      pc    <= PC_INIT;
    end else begin
      if (redirect_valid)
        pc <= redirect_pc;
      else if (push)
        pc <= next_pc;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

  instr_fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .W     (EW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .count (q_count)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed bench for instr_fetch_unit
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [10:0] rom_addr;
  logic [21:0] rom_data;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [21:0] instr_data;
  logic [10:0] instr_pc;
  logic        instr_pred;
  logic        redirect_valid = 1'b0;
  logic [10:0] redirect_pc = '0;
  logic        busy;
  logic        b_en = 1'b0;
  int          passed = 0;
  int          total = 0;

`ifdef FETCH_BRANCH_PREDECODE_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [21:0] rom_word(input logic [10:0] a);
    if (b_en && a == 11'd9) return {5'b10010, 6'd0, 11'd20};
    return {6'b000111, 5'd0, a};
  endfunction

  assign rom_data = rom_word(rom_addr);

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_pred     (instr_pred),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0; b_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid); else passed++;
    total++; if (instr_data !== 22'd0) $display("FAIL reset_data got %h want 0", instr_data); else passed++;
    total++; if (instr_pc !== 11'd0) $display("FAIL reset_pc got %0d want 0", instr_pc); else passed++;
    total++; if (instr_pred !== 1'b0) $display("FAIL reset_pred got %b want 0", instr_pred); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (rom_addr !== 11'd0) $display("FAIL reset_rom_addr got %0d want 0", rom_addr); else passed++;
  endtask

  task automatic test_sequential();
    do_reset();
    instr_ready = 1'b1;
    do_start();
    total++; if (busy !== 1'b1) $display("FAIL seq_busy got %b want 1", busy); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL seq_first_valid got %b want 0", instr_valid); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 11'(i) || instr_data !== rom_word(11'(i)))
        $display("FAIL seq_pc%0d got v=%b pc=%0d d=%h want v=1 pc=%0d d=%h", i, instr_valid, instr_pc, instr_data, i, rom_word(11'(i)));
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) tick();
    total++; if (rom_addr !== 11'd2) $display("FAIL bp_stall_addr got %0d want 2", rom_addr); else passed++;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 11'd0) $display("FAIL bp_head_hold got v=%b pc=%0d want v=1 pc=0", instr_valid, instr_pc); else passed++;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 11'(i))
        $display("FAIL bp_drain%0d got v=%b pc=%0d want v=1 pc=%0d", i, instr_valid, instr_pc, i);
      else passed++;
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    instr_ready = 1'b1;
    do_start();
    for (int i = 0; i < 6; i++) tick();
    instr_ready = 1'b0;
    tick();
    total++; if (instr_pc !== 11'd5 || rom_addr !== 11'd7) $display("FAIL redir_pre got head=%0d addr=%0d want head=5 addr=7", instr_pc, rom_addr); else passed++;
    redirect_valid = 1'b1; redirect_pc = 11'd12; instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0) $display("FAIL redir_flush got valid=%b want 0", instr_valid); else passed++;
    total++; if (rom_addr !== 11'd12) $display("FAIL redir_addr got %0d want 12", rom_addr); else passed++;
    tick();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 11'd12) $display("FAIL redir_target got v=%b pc=%0d want v=1 pc=12", instr_valid, instr_pc); else passed++;
    tick();
    total++; if (instr_pc !== 11'd13) $display("FAIL redir_next got pc=%0d want 13", instr_pc); else passed++;
  endtask

  task automatic test_wrap();
    logic [10:0] exp_pc [4];
    exp_pc[0] = 11'd2046; exp_pc[1] = 11'd2047; exp_pc[2] = 11'd0; exp_pc[3] = 11'd1;
    do_reset();
    do_start();
    redirect_valid = 1'b1; redirect_pc = 11'd2046; instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i])
        $display("FAIL wrap%0d got v=%b pc=%0d want v=1 pc=%0d", i, instr_valid, instr_pc, exp_pc[i]);
      else passed++;
    end
  endtask

  task automatic test_branch();
    logic [10:0] exp_pc [4];
    logic        exp_pred [4];
    exp_pc[0] = 11'd8; exp_pc[1] = 11'd9;
    exp_pc[2] = PRED_EN ? 11'd20 : 11'd10;
    exp_pc[3] = PRED_EN ? 11'd21 : 11'd11;
    exp_pred[0] = 1'b0; exp_pred[1] = PRED_EN; exp_pred[2] = 1'b0; exp_pred[3] = 1'b0;
    do_reset();
    b_en = 1'b1;
    instr_ready = 1'b1;
    do_start();
    for (int i = 0; i < 9; i++) tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i] || instr_pred !== exp_pred[i] || instr_data !== rom_word(exp_pc[i]))
        $display("FAIL branch%0d got v=%b pc=%0d pred=%b d=%h want pc=%0d pred=%b d=%h", i, instr_valid, instr_pc, instr_pred, instr_data, exp_pc[i], exp_pred[i], rom_word(exp_pc[i]));
      else passed++;
      tick();
    end
  endtask

  task automatic test_reset_and_stop();
    do_reset();
    do_start();
    tick(); tick();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 11'd33;
    tick();
    rst = 1'b0; redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 11'd0)
      $display("FAIL rst_override got v=%b busy=%b addr=%0d want 0 0 0", instr_valid, busy, rom_addr); else passed++;
    do_start();
    tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || rom_addr !== 11'd2) $display("FAIL stop_freeze got busy=%b addr=%0d want 0 2", busy, rom_addr); else passed++;
    instr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 11'(i)) $display("FAIL stop_drain%0d got v=%b pc=%0d want v=1 pc=%0d", i, instr_valid, instr_pc, i);
      else passed++;
      tick();
    end
    total++; if (instr_valid !== 1'b0 || rom_addr !== 11'd2) $display("FAIL stop_empty got v=%b addr=%0d want 0 2", instr_valid, rom_addr); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_branch();
    test_reset_and_stop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the program-memory ROM.
- Owns the program counter (PC) and drives the combinational ROM address.
- Captures each returned 22-bit instruction with its PC into a small queue.
- Presents queued instructions to the decoder over a valid/ready handshake; accepts PC redirects (taken branches) from execute.

Parameters:
ADDR_W, 11, PC / ROM address width
INSTR_W, 22, instruction width; opcode is bits [INSTR_W-1:INSTR_W-5]
RESET_PC, 0, PC value loaded at reset and on start
QUEUE_DEPTH, 2, instruction queue entries; power of two, 2..8

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  pulse: load PC=RESET_PC, enter RUN
stop  in  1  pulse: stop fetching, enter IDLE
rom_addr  out  ADDR_W  address to program ROM, equals PC register
rom_data  in  INSTR_W  combinational ROM data for rom_addr
instr_valid  out  1  queue head valid
instr_ready  in  1  decoder accepts head
instr_data  out  INSTR_W  head instruction; 0 when instr_valid=0
instr_pc  out  ADDR_W  head instruction address; 0 when instr_valid=0
instr_pred  out  1  head was a predecoded unconditional branch (see Optional Feature)
redirect_valid  in  1  taken-branch redirect from execute
redirect_pc  in  ADDR_W  redirect target
busy  out  1  high in RUN state

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, PC=RESET_PC, queue empty, count=0.
  - Outputs: instr_valid=0, instr_data=0, instr_pc=0, instr_pred=0, busy=0, rom_addr=RESET_PC.
  - rst overrides all other inputs, including mid-operation; queue contents are discarded.
- States:
  - IDLE: no fetch. start -> RUN with PC=RESET_PC and queue flushed.
  - RUN: fetching. stop -> IDLE; PC holds; queued entries remain deliverable.
  - start and stop in the same cycle: start wins.
- Signals:
  - pop = instr_valid & instr_ready.
  - push = (state==RUN) & ~redirect_valid & ~stop & (count<QUEUE_DEPTH | pop).
- On push:
  - Enqueue {rom_data, PC}; PC <= PC+1, mod 2^ADDR_W (2047 -> 0 wraps silently).
  - Full queue with simultaneous pop: push allowed, count unchanged.
- redirect_valid (any state):
  - At that edge: queue flushed (a coincident pop is dropped, not delivered); PC <= redirect_pc; no push.
  - State unchanged. In IDLE, PC is loaded but nothing is fetched until start; start then reloads RESET_PC.
  - redirect_valid and start in the same cycle: start wins.
- Latency:
  - Instruction at PC is fetched in cycle N and is on instr_* from cycle N+1.
  - Redirect at edge N: target fetched in cycle N+1, valid at N+2.
  - Sustained throughput is 1 instruction/cycle when instr_ready is held high.
- Handshake rules:
  - instr_data/instr_pc/instr_pred are stable while instr_valid=1 and instr_ready=0.
  - instr_valid never drops without a pop, except on redirect, start, or rst.
- Queue: circular buffer with head/tail pointers plus count (0..QUEUE_DEPTH); FIFO order preserved.

Optional Feature:
FETCH_BRANCH_PREDECODE_EN
- Defined:
  - When pushing an instruction whose opcode is 5'b10010 (B, unconditional), PC <= rom_data[ADDR_W-1:0] instead of PC+1.
  - The entry is stored with pred=1 and surfaces on instr_pred.
  - Downstream must not redirect for a pred=1 instruction.
- Undefined: B is fetched sequentially like any other instruction; instr_pred is tied 0.

Test Plan:
1. Reset, start, instr_ready=1, ROM returns addr-tagged data -> instr_pc = 0,1,2,3 on consecutive cycles from 1 cycle after start; busy=1.
2. instr_ready=0 after start -> exactly QUEUE_DEPTH=2 entries fetched (PC stalls at 2, rom_addr=2); release ready -> pc 0,1,2 delivered in order, none lost or duplicated.
3. redirect_valid with redirect_pc=12 while queue holds pc 5,6 -> instr_valid=0 next cycle; following cycle instr_pc=12; pc 5,6 never delivered.
4. Preload PC=2046 via redirect, run -> instr_pc 2046, 2047, 0, 1.
5. ROM holds B (opcode 10010, target 20) at addr 9:
   - with FETCH_BRANCH_PREDECODE_EN -> instr_pc sequence 8, 9 (instr_pred=1), 20, 21.
   - without -> sequence 8, 9, 10 and instr_pred=0.
6. Assert rst while queue full and redirect_valid=1 -> next cycle instr_valid=0, busy=0, rom_addr=RESET_PC; stop mid-run -> PC frozen, remaining queued entries still drain.
